input_debounce_bank: RTL
========================

// Module: input_debounce_bank
// PURPOSE
//  Parametrised multi-channel debouncer and edge detector for switches and buttons.
//  Sits between the board pins (sw, btnC, btnD) and all consumers.
//  Per channel it provides a clean level, rise/fall pulses, a press-toggle and a long-press event.
//  Each channel uses a counter-based stable-time filter; sampling is paced by an internal tick prescaler.
// PARAMETERS
//  CHANNELS      16           number of independent input channels
//  SYNC_STAGES   2            synchroniser flops per channel (>=2)
//  TICK_DIV      100_000      CLOCK cycles per sample tick (1 kHz at 100 MHz)
//  STABLE_TICKS  10           consecutive differing tick samples needed to flip level (>=1)
//  LONG_TICKS    1000         ticks level must stay 1 before long_press fires (>=1)
//  INIT_LEVEL    {CHANNELS{1'b0}}  per-channel reset value of level/toggle
// PORTS
//  CLOCK       in   1         system clock (100 MHz)
//  rst_n       in   1         asynchronous, active-low reset
//  raw_in      in   CHANNELS  unsynchronised pin inputs
//  level       out  CHANNELS  debounced level
//  rise        out  CHANNELS  1-cycle pulse on level 0->1
//  fall        out  CHANNELS  1-cycle pulse on level 1->0
//  toggle      out  CHANNELS  inverts on every rise
//  long_press  out  CHANNELS  1-cycle pulse when level held 1 for LONG_TICKS ticks
//  any_change  out  1         OR of all rise|fall, same cycle
//  tick        out  1         sample-tick strobe, exported for debug/sharing
// BEHAVIOUR
//  Reset (rst_n=0, async): sync chain<=0, prescaler<=0, all counters<=0, level<=INIT_LEVEL,
//   toggle<=INIT_LEVEL, rise/fall/long_press/any_change/tick<=0.
//  Synchroniser: raw_in passes SYNC_STAGES flops; the last stage is s[i].
//  Prescaler: counts 0..TICK_DIV-1 and wraps. tick=1 for the one cycle after the count reaches TICK_DIV-1.
//   The first tick comes TICK_DIV cycles after reset release.
//  Stable counter per channel: width $clog2(STABLE_TICKS+1). Updates only on tick cycles:
//   - s[i]==level[i]: cnt<=0.
//   - s[i]!=level[i] and cnt==STABLE_TICKS-1: level[i]<=~level[i], cnt<=0.
//   - otherwise: cnt<=cnt+1.
//   A glitch shorter than STABLE_TICKS ticks never changes level.
//   Worst-case latency is SYNC_STAGES + STABLE_TICKS*TICK_DIV cycles.
//  Edge pulses (rise, fall) are registered and high in the first cycle level shows its new value, for exactly 1 cycle.
//   toggle flips in that same cycle on rise.
//  Hold counter per channel: width $clog2(LONG_TICKS+1).
//   - Cleared whenever level[i]==0.
//   - On each tick with level[i]==1: increments, saturating at LONG_TICKS.
//   - long_press pulses for 1 cycle on the tick where it reaches LONG_TICKS. It fires once per press; no repeat.
//   - A new press must fall and rise again to re-arm.
//  Channels are fully independent: simultaneous flips on any channels in one tick all pulse in the same cycle.
//   any_change is a single 1-cycle pulse covering all of them.
//  Reset mid-count discards all partial counts. After release, a full STABLE_TICKS window is needed before any flip.
//   No edge pulse is generated by reset itself, even if raw_in != INIT_LEVEL.
//  Fully synchronous to CLOCK apart from the async reset; no combinational path from raw_in to any output.
// TESTING (sim params: TICK_DIV=4, STABLE_TICKS=3, LONG_TICKS=8, CHANNELS=8, INIT_LEVEL=8'h80)
//  1. Hold rst_n=0 with raw_in=8'hFF -> level=8'h80, toggle=8'h80, all pulses 0.
//     Release: no rise pulse for 2+12 cycles, then ch0..6 rise together, any_change one cycle.
//  2. raw_in[0] 0->1 and held -> level[0]=1 within 2+3*4+4 cycles; rise[0] exactly 1 cycle; toggle[0]=1.
//     A second full press/release cycle returns toggle[0] to 0.
//  3. raw_in[1] high for 2 ticks (8 cycles), then low -> level[1], rise[1] and fall[1] stay 0 throughout.
//  4. Hold raw_in[2]=1 for 20 ticks -> long_press[2] pulses once, 8 ticks after rise[2], with no further pulses.
//     Release and re-press -> fires again.
//  5. Same tick: ch3 0->1 and ch7 1->0 stable -> rise[3] and fall[7] in the same cycle; any_change high 1 cycle.
//  6. rst_n pulsed low after 2 stable ticks of a change on ch4 -> level[4] back to INIT, no pulse.
//     After release, the change needs a full 3 ticks to take effect.

Source files
------------

// File: rtl/input_debounce_bank.sv
// Multi-channel switch/button debouncer with edge, toggle and long-press detection.
// Latency: SYNC_STAGES flops, then STABLE_TICKS sample ticks (TICK_DIV cycles each) before the level flips.
// Backpressure: none; free-running, every output is a registered level or 1-cycle strobe.
//
// Ports:
//   CLOCK       system clock
//   rst_n       asynchronous active-low reset
//   raw_in      unsynchronised pin inputs, one bit per channel
//   level       debounced level per channel
//   rise/fall   1-cycle strobes on level 0->1 / 1->0
//   toggle      inverts on every rise
//   long_press  1-cycle strobe once level has been 1 for LONG_TICKS ticks
//   any_change  OR of all rise|fall strobes, same cycle
//   tick        sample-tick strobe, exported for sharing/debug
module input_debounce_bank #(
    parameter int                     CHANNELS     = 16,
    parameter int                     SYNC_STAGES  = 2,
    parameter int                     TICK_DIV     = 100_000,
    parameter int                     STABLE_TICKS = 10,
    parameter int                     LONG_TICKS   = 1000,
    parameter logic [CHANNELS-1:0]    INIT_LEVEL   = '0
) (
    input  logic                CLOCK,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] raw_in,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] toggle,
    output logic [CHANNELS-1:0] long_press,
    output logic                any_change,
    output logic                tick
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(STABLE_TICKS + 1);
    localparam int HW = $clog2(LONG_TICKS + 1);

    localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_TICKS - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_TICKS);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_TICKS - 1);

    // ------------------------------------------------------------------
    // Input synchroniser: stage 0 takes raw_in, last stage feeds the filter.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0][CHANNELS-1:0] r_sync;
    logic [CHANNELS-1:0]                  w_s;

    always_ff @(posedge CLOCK or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], raw_in};
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Tick prescaler. The strobe is registered, so it appears in the cycle
    // after the count reaches its last value; filters act on that cycle.
    // ------------------------------------------------------------------
    logic [PW-1:0] r_pre;
    logic          r_tick;

    always_ff @(posedge CLOCK or negedge rst_n) begin
        if (!rst_n) begin
            r_pre  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= (r_pre == PRE_LAST);
            r_pre  <= (r_pre == PRE_LAST) ? '0 : r_pre + PW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Per-channel stable-time filter and long-press hold counter.
    // ------------------------------------------------------------------
    logic [CHANNELS-1:0][CW-1:0] r_cnt;
    logic [CHANNELS-1:0][CW-1:0] w_cnt_nxt;
    logic [CHANNELS-1:0][HW-1:0] r_hold;
    logic [CHANNELS-1:0][HW-1:0] w_hold_nxt;
    logic [CHANNELS-1:0]         w_flip;
    logic [CHANNELS-1:0]         w_lp_nxt;

    logic [CHANNELS-1:0] r_level;
    logic [CHANNELS-1:0] r_rise;
    logic [CHANNELS-1:0] r_fall;
    logic [CHANNELS-1:0] r_toggle;
    logic [CHANNELS-1:0] r_lp;
    logic                r_any;

    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_hold_nxt = r_hold;
        w_flip     = '0;
        w_lp_nxt   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            // Any tick sample matching the current level restarts the window,
            // so only an unbroken run of differing samples flips the level.
            if (r_tick) begin
                if (w_s[i] == r_level[i]) begin
                    w_cnt_nxt[i] = '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    w_flip[i]    = 1'b1;
                    w_cnt_nxt[i] = '0;
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + CW'(1);
                end
            end
            // Saturating at LONG_TICKS is what stops long_press from repeating
            // until the level has dropped (clearing the count) and risen again.
            if (!r_level[i]) begin
                w_hold_nxt[i] = '0;
            end else if (r_tick && (r_hold[i] != HOLD_MAX)) begin
                w_hold_nxt[i] = r_hold[i] + HW'(1);
                w_lp_nxt[i]   = (r_hold[i] == HOLD_LAST);
            end
        end
    end

    always_ff @(posedge CLOCK or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_hold   <= '0;
            r_level  <= INIT_LEVEL;
            r_toggle <= INIT_LEVEL;
            r_rise   <= '0;
            r_fall   <= '0;
            r_lp     <= '0;
            r_any    <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_hold   <= w_hold_nxt;
            // Strobes are registered alongside the level so they line up with
            // the first cycle the new level is visible.
            r_level  <= r_level ^ w_flip;
            r_rise   <= w_flip & ~r_level;
            r_fall   <= w_flip & r_level;
            r_toggle <= r_toggle ^ (w_flip & ~r_level);
            r_lp     <= w_lp_nxt;
            r_any    <= |w_flip;
        end
    end

    assign level      = r_level;
    assign rise       = r_rise;
    assign fall       = r_fall;
    assign toggle     = r_toggle;
    assign long_press = r_lp;
    assign any_change = r_any;
    assign tick       = r_tick;

endmodule
